ss_signed_stream_decoder: RTL and testbench
===========================================

# ss_signed_stream_decoder

Receive-side converter for the signed stochastic bitstreams that the signed add/sub blocks produce. Each stream carries a value bit and a per-cycle sign bit. Over a window of 2^W_LOG enabled cycles the block counts positive ones minus negative ones, then presents the signed result in two forms: two's complement and sign-magnitude. A VALID/READY handshake delivers the result to the binary side, which is a controller, a readout or a training logic.

## Interface
- W_LOG, default 4: window length N = 2^W_LOG enabled cycles.
- CONTINUOUS, default 0:
  - 1: the next window starts automatically, with no gap.
  - 0: the block returns to IDLE after each window.
- CLK, input, 1: the single clock. All state changes on its rising edge.
- INIT_n, input, 1: reset, asynchronous and active-low.
- EN, input, 1: sample qualifier. When low, the sample is ignored and the window counter holds.
- START, input, 1: one-cycle pulse that begins a window. Honoured only in IDLE.
- IN, input, 1: stochastic value bit.
- SIGN, input, 1: sign of the current IN bit; 1 means negative.
- READY, input, 1: consumer accepts the result.
- VALID, output, 1: a result is held in the output registers.
- DOUT, output, W_LOG+2: signed two's-complement result, in the range −N..+N.
- DOUT_MAG, output, W_LOG+1: magnitude of DOUT.
- DOUT_SIGN, output, 1: 1 if DOUT < 0. Zero is always reported with sign 0.
- BUSY, output, 1: high in ACCUM.
- OVERRUN, output, 1: sticky. Set when a result was overwritten while still unaccepted.

## Operation
- States: IDLE, ACCUM.
- IDLE → ACCUM on START; the accumulator and window counter are cleared on the same edge.
- Sampling in ACCUM, only when EN=1:
  - IN&~SIGN → accumulator +1.
  - IN&SIGN → accumulator −1.
  - IN=0 → no change.
  - The window counter increments.
- Accumulator: signed, W_LOG+2 bits. It cannot overflow, because |count| ≤ N.
- Window end is the enabled cycle with counter == N−1. On that edge:
  - DOUT, DOUT_MAG and DOUT_SIGN load acc+sample (the final sample is included).
  - VALID is set.
  - If VALID=1 and READY=0 at that edge, OVERRUN is set and the old result is overwritten.
- After the window end:
  - CONTINUOUS=1: the accumulator and counter clear and the block stays in ACCUM.
  - CONTINUOUS=0: the block goes to IDLE.
- START in ACCUM is ignored. EN has no effect in IDLE.
- Handshake: VALID&READY on an edge clears VALID. If a new result loads on that same edge, VALID stays set, the new data loads and OVERRUN is not set.
- OVERRUN clears only on reset.
- Reset (INIT_n=0), at any time including mid-window:
  - State → IDLE.
  - Accumulator, counter, DOUT, DOUT_MAG, DOUT_SIGN, VALID, BUSY and OVERRUN → 0.
  - The partial window is discarded.

## Timing
- The START edge counts as cycle 0. The first sample is taken on edge 1.
- With EN held high, the last sample is taken on edge N and VALID is high after edge N. Latency from the last sample to VALID is 1 cycle.
- Each EN=0 cycle extends the window by one cycle.
- Result outputs are registered and stable while VALID=1, until the next window end or reset.
- BUSY rises after the START edge and falls after the window-end edge (CONTINUOUS=0 only).
- In continuous mode windows are back to back: the sample on the edge after a window end is sample 0 of the next window.

## Structure
- Shared package/header `ss_pkg` holds:
  - the state encodings (ST_IDLE, ST_ACCUM);
  - the sign convention constant (SIGN_NEG = 1'b1), shared with the add/sub blocks.
- Sub-module `ss_updown_acc` is the signed ±1 accumulator, with sync clear and EN, parameterised on width.
- The window counter, FSM, output register, sign-magnitude conversion and handshake live in the top module.

## Test plan
All scenarios use W_LOG=4 (N=16).
- Reset: INIT_n low mid-window with 7 positive samples accumulated → all outputs 0, state IDLE. A later START produces a clean window.
- 16 samples IN=1, SIGN=0, READY=1 → VALID high for one cycle after edge 16, DOUT=+16 (6'b010000), DOUT_MAG=16, DOUT_SIGN=0.
- 16 samples IN=1, SIGN=1 → DOUT=−16 (6'b110000), DOUT_MAG=16, DOUT_SIGN=1.
- Alternating +1/−1 with four IN=0 cycles mixed in → DOUT=0, DOUT_SIGN=0, DOUT_MAG=0.
- 10 positive samples, then EN=0 for 5 cycles, then 6 negative samples → VALID after edge 21, DOUT=+4.
- CONTINUOUS=1, READY=0, two windows (+16 then −2) → OVERRUN=1, DOUT=−2. A later READY=1 pulse clears VALID, and OVERRUN stays 1.

Source files
------------

// File: rtl/ss_pkg.sv
// Shared definitions for the signed stochastic stream blocks.
// The sign encoding matches the signed add/sub producers.
package ss_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_e;

  localparam logic SIGN_NEG = 1'b1;

endpackage

// File: rtl/ss_signed_stream_decoder_if.sv
// Result port of the stream decoder: VALID/READY handshake plus the decoded value in both forms.
interface ss_signed_stream_decoder_if #(
  parameter int W_LOG = 4
);

  logic                   valid;
  logic                   ready;
  logic signed [W_LOG+1:0] dout;
  logic [W_LOG:0]          doutMag;
  logic                    doutSign;

  modport master (output valid, dout, doutMag, doutSign, input ready);
  modport slave  (input valid, dout, doutMag, doutSign, output ready);

endinterface

// File: rtl/ss_updown_acc.sv
// Signed +1/-1 accumulator with synchronous clear and enable.
// sum_o is the value the accumulator would take if the current step were applied.
module ss_updown_acc #(
  parameter int WIDTH = 6
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clr_i,
  input  logic                    en_i,
  input  logic                    up_i,
  input  logic                    dn_i,
  output logic signed [WIDTH-1:0] sum_o
);

  localparam logic signed [WIDTH-1:0] ONE = WIDTH'(1);

  logic signed [WIDTH-1:0] acc_q, acc_d;

  always_comb begin
    sum_o = acc_q;
    if (up_i && !dn_i) begin
      sum_o = acc_q + ONE;
    end else if (dn_i && !up_i) begin
      sum_o = acc_q - ONE;
    end
  end

  // Clear wins over a simultaneous step so a new window starts from zero.
  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = sum_o;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/ss_signed_stream_decoder.sv
// Signed stochastic stream decoder: counts positive minus negative ones over 2^W_LOG
// enabled cycles and delivers the result as two's complement and sign-magnitude.
module ss_signed_stream_decoder
  import ss_pkg::*;
#(
  parameter int W_LOG      = 4,
  parameter bit CONTINUOUS = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic start_i,
  input  logic in_i,
  input  logic sign_i,
  output logic busy_o,
  output logic overrun_o,
  ss_signed_stream_decoder_if.master resIf
);

  localparam int DW = W_LOG + 2;
  localparam logic [W_LOG-1:0] LAST = '1;

  state_e state_q, state_d;
  logic [W_LOG-1:0] winCnt_q, winCnt_d;
  logic signed [DW-1:0] dout_q, dout_d;
  logic [W_LOG:0] mag_q, mag_d;
  logic sign_q, sign_d;
  logic valid_q, valid_d;
  logic overrun_q, overrun_d;

  logic accClr, accEn, winEnd, isNeg;
  logic signed [DW-1:0] accSum;
  logic [W_LOG:0] magNext;

  assign isNeg = (sign_i == SIGN_NEG);

  ss_updown_acc #(
    .WIDTH(DW)
  ) uAcc (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .clr_i (accClr),
    .en_i  (accEn),
    .up_i  (in_i & ~isNeg),
    .dn_i  (in_i & isNeg),
    .sum_o (accSum)
  );

  // Magnitude fits in W_LOG+1 bits because |count| never exceeds N.
  assign magNext = (W_LOG+1)'(accSum[DW-1] ? -accSum : accSum);

  always_comb begin
    state_d  = state_q;
    winCnt_d = winCnt_q;
    accClr   = 1'b0;
    accEn    = 1'b0;
    winEnd   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d  = ST_ACCUM;
          winCnt_d = '0;
          accClr   = 1'b1;
        end
      end
      ST_ACCUM: begin
        if (en_i) begin
          accEn    = 1'b1;
          winCnt_d = winCnt_q + 1'b1;
          if (winCnt_q == LAST) begin
            winEnd   = 1'b1;
            winCnt_d = '0;
            if (CONTINUOUS) begin
              accClr = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A load on the same edge as an accept keeps VALID high and is not an overrun.
  always_comb begin
    dout_d    = dout_q;
    mag_d     = mag_q;
    sign_d    = sign_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (valid_q && resIf.ready) begin
      valid_d = 1'b0;
    end
    if (winEnd) begin
      dout_d  = accSum;
      mag_d   = magNext;
      sign_d  = accSum[DW-1] ? SIGN_NEG : ~SIGN_NEG;
      valid_d = 1'b1;
      if (valid_q && !resIf.ready) begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      winCnt_q  <= '0;
      dout_q    <= '0;
      mag_q     <= '0;
      sign_q    <= 1'b0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      winCnt_q  <= winCnt_d;
      dout_q    <= dout_d;
      mag_q     <= mag_d;
      sign_q    <= sign_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign busy_o         = (state_q == ST_ACCUM);
  assign overrun_o      = overrun_q;
  assign resIf.valid    = valid_q;
  assign resIf.dout     = dout_q;
  assign resIf.doutMag  = mag_q;
  assign resIf.doutSign = sign_q;

endmodule

// File: tb/tb_ss_signed_stream_decoder.sv
// Self-checking bench: one single-shot and one continuous decoder (N=16) share the stimulus;
// single-shot results are checked through a scoreboard, the continuous one directly.
module tb_ss_signed_stream_decoder;

  typedef struct {
    int dout;
    int mag;
    int sgn;
  } res_t;

  logic clk = 1'b0;
  logic rstN;
  logic en, start, inBit, sgn;
  logic busyA, overA, busyC, overC;

  int total = 0;
  int bad = 0;
  res_t expectQ[$];
  res_t expNow;
  int stimQ[$];

  ss_signed_stream_decoder_if #(.W_LOG(4)) ifA ();
  ss_signed_stream_decoder_if #(.W_LOG(4)) ifC ();

  ss_signed_stream_decoder #(
    .W_LOG(4),
    .CONTINUOUS(1'b0)
  ) dutA (
    .clk_i    (clk),
    .rst_ni   (rstN),
    .en_i     (en),
    .start_i  (start),
    .in_i     (inBit),
    .sign_i   (sgn),
    .busy_o   (busyA),
    .overrun_o(overA),
    .resIf    (ifA)
  );

  ss_signed_stream_decoder #(
    .W_LOG(4),
    .CONTINUOUS(1'b1)
  ) dutC (
    .clk_i    (clk),
    .rst_ni   (rstN),
    .en_i     (en),
    .start_i  (start),
    .in_i     (inBit),
    .sign_i   (sgn),
    .busy_o   (busyC),
    .overrun_o(overC),
    .resIf    (ifC)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Each stimQ entry: +1 positive one, -1 negative one, 0 IN=0, 2 EN low.
  task automatic applyStimulus(input bit doStart, input bit pushExp, input bit checkA);
    int sum;
    res_t e;
    sum = 0;
    foreach (stimQ[i]) begin
      if (stimQ[i] != 2) sum += stimQ[i];
    end
    if (pushExp) begin
      e.dout = sum;
      e.mag  = (sum < 0) ? -sum : sum;
      e.sgn  = (sum < 0) ? 1 : 0;
      expectQ.push_back(e);
    end
    if (doStart) begin
      start = 1'b1; en = 1'b0; inBit = 1'b0; sgn = 1'b0;
      tick();
      start = 1'b0;
    end
    foreach (stimQ[i]) begin
      en    = (stimQ[i] != 2);
      inBit = (stimQ[i] == 1) || (stimQ[i] == -1);
      sgn   = (stimQ[i] == -1);
      if (checkA && i == stimQ.size() - 1) checkOutput("validBeforeLastEdge", int'(ifA.valid), 0);
      tick();
    end
    en = 1'b0; inBit = 1'b0; sgn = 1'b0;
    if (checkA) checkOutput("validAfterLastEdge", int'(ifA.valid), 1);
  endtask

  always @(negedge clk) begin
    if (rstN && ifA.valid && ifA.ready) begin
      if (expectQ.size() == 0) begin
        checkOutput("unexpectedResult", 1, 0);
      end else begin
        expNow = expectQ.pop_front();
        checkOutput("dout", int'(ifA.dout), expNow.dout);
        checkOutput("doutMag", int'(ifA.doutMag), expNow.mag);
        checkOutput("doutSign", int'(ifA.doutSign), expNow.sgn);
      end
    end
  end

  initial begin
    rstN = 1'b0; en = 1'b0; start = 1'b0; inBit = 1'b0; sgn = 1'b0;
    ifA.ready = 1'b1;
    ifC.ready = 1'b0;
    repeat (3) tick();
    checkOutput("resetValid", int'(ifA.valid), 0);
    checkOutput("resetBusy", int'(busyA), 0);
    checkOutput("resetDout", int'(ifA.dout), 0);
    rstN = 1'b1;
    tick();

    $display("[TB] all positive window");
    stimQ.delete();
    repeat (16) stimQ.push_back(1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("busyDuringFinalCycle", int'(busyA), 0);
    tick();
    checkOutput("validOneCycle", int'(ifA.valid), 0);
    checkOutput("doutHeld", int'(ifA.dout), 16);

    $display("[TB] reset mid-window");
    stimQ.delete();
    repeat (7) stimQ.push_back(1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("busyMidWindow", int'(busyA), 1);
    rstN = 1'b0;
    #2;
    checkOutput("rstDout", int'(ifA.dout), 0);
    checkOutput("rstMag", int'(ifA.doutMag), 0);
    checkOutput("rstSign", int'(ifA.doutSign), 0);
    checkOutput("rstValid", int'(ifA.valid), 0);
    checkOutput("rstBusy", int'(busyA), 0);
    checkOutput("rstOverrun", int'(overA), 0);
    @(posedge clk);
    #1;
    rstN = 1'b1;
    tick();
    stimQ.delete();
    repeat (3) stimQ.push_back(1);
    repeat (13) stimQ.push_back(0);
    applyStimulus(1'b1, 1'b1, 1'b1);
    tick();

    $display("[TB] all negative window");
    stimQ.delete();
    repeat (16) stimQ.push_back(-1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    tick();

    $display("[TB] alternating with zeros");
    stimQ.delete();
    for (int k = 0; k < 6; k++) begin
      stimQ.push_back(1);
      stimQ.push_back(-1);
      if (k % 2 == 1) stimQ.push_back(0);
    end
    stimQ.push_back(0);
    applyStimulus(1'b1, 1'b1, 1'b1);
    tick();

    $display("[TB] enable gap");
    stimQ.delete();
    repeat (10) stimQ.push_back(1);
    repeat (5) stimQ.push_back(2);
    repeat (6) stimQ.push_back(-1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    tick();

    $display("[TB] continuous overrun");
    rstN = 1'b0;
    tick();
    rstN = 1'b1;
    tick();
    stimQ.delete();
    repeat (16) stimQ.push_back(1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("contValid1", int'(ifC.valid), 1);
    checkOutput("contDout1", int'(ifC.dout), 16);
    checkOutput("contOverrun1", int'(overC), 0);
    stimQ.delete();
    repeat (7) stimQ.push_back(1);
    repeat (9) stimQ.push_back(-1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("contValid2", int'(ifC.valid), 1);
    checkOutput("contOverrun2", int'(overC), 1);
    checkOutput("contDout2", int'(ifC.dout), -2);
    checkOutput("contMag2", int'(ifC.doutMag), 2);
    checkOutput("contSign2", int'(ifC.doutSign), 1);
    checkOutput("contBusy", int'(busyC), 1);
    ifC.ready = 1'b1;
    tick();
    ifC.ready = 1'b0;
    checkOutput("contValidCleared", int'(ifC.valid), 0);
    checkOutput("contOverrunSticky", int'(overC), 1);
    checkOutput("contDoutStable", int'(ifC.dout), -2);

    repeat (2) tick();
    checkOutput("queueDrained", expectQ.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
